count_bcd_conv: RTL
===================

Name: count_bcd_conv

Overview:
- Downstream stage of the 8-bit `counter`; converts its `count` value to packed BCD for the display driver.
- Sequential double-dabble engine with a start/ready/valid handshake.
- Also keeps a sticky record of the counter's `ovf` pulses until software or the display logic clears it.

Parameters:
- WIDTH, 8: binary input width.
- DIGITS, 3: number of BCD output digits. Must be ≥ ceil(WIDTH·log10 2); elaboration fails otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request conversion of `bin`; accepted only when `ready`=1.
- bin  in  WIDTH  binary value, normally counter `count`; sampled on the accept cycle.
- ovf_in  in  1  counter `ovf` pulse.
- clr_ovf  in  1  clears `ovf_sticky`.
- ready  out  1  high in IDLE; a conversion can be accepted.
- valid  out  1  one-cycle pulse when `bcd` updates.
- bcd  out  4·DIGITS  packed BCD result, digit 0 in the LSBs; holds the last result.
- ovf_sticky  out  1  set by any `ovf_in`; held until cleared.

Behaviour:
- Reset (synchronous, any state):
  - state=IDLE, ready=1, valid=0, bcd=0, ovf_sticky=0.
  - Internal shift registers = 0.
  - A conversion in flight is aborted with no valid pulse.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If start=1, latch `bin` into the shift register and clear the BCD accumulator.
  - Load the iteration counter with WIDTH, then go to CONV. ready=0 from the next cycle.
- CONV, one iteration per cycle:
  - Every BCD digit ≥5 gets +3.
  - The whole {accumulator, binary} register is then shifted left by 1.
  - The iteration counter is decremented. After the WIDTH-th iteration, go to DONE.
- DONE, one cycle:
  - bcd ← accumulator, valid=1, ready=0.
  - Next state is IDLE.
- Latency: accept at cycle 0 → valid at cycle WIDTH+1 (9 for the defaults) → ready at cycle WIDTH+2.
  - Minimum issue interval is WIDTH+2 cycles.
- start while ready=0 is ignored, with no queuing. `bin` is don't-care outside the accept cycle.
- `bcd` changes only in the DONE cycle. Digits are always in 0–9.
- The iteration counter is sized to hold WIDTH; it does not wrap mid-conversion.
- ovf_sticky:
  - Next value is (ovf_sticky & ~clr_ovf) | ovf_in, so set wins over clear in the same cycle.
  - It is independent of the FSM.
- Zero input gives all-zero digits. The maximum input (2^WIDTH−1) must convert exactly; for 255 that is 0x255.

Optional Feature:
- Macro: COUNT_BCD_BLANK_EN.
- Defined: adds output `blank [DIGITS-1:0]`, updated together with `bcd` in the DONE cycle.
  - blank[i]=1 when digit i and every higher digit are 0, for i ≥ 1.
  - blank[0] is always 0.
  - Reset value is {DIGITS-1{1'b1}, 1'b0}.
- Undefined: no `blank` port; all other behaviour is identical.

Decomposition:
- Shared package, count_bcd_pkg:
  - FSM state encoding (IDLE/CONV/DONE, 2-bit).
  - BCD digit width constant (4).
  - Add-3 threshold constant (5).
- One natural sub-module: bcd_add3_digit, a combinational 4-bit "≥5 then +3" cell instantiated DIGITS times.

Test Plan:
- Reset, then bin=0 with start → valid after 9 cycles, bcd=0x000, ready returns 1 one cycle later.
- bin=255 → bcd=0x255. bin=99 → 0x099. bin=100 → 0x100. bin=9 → 0x009.
- start pulsed each cycle with bin changing during CONV → only the first value converts; bcd matches the accept-cycle bin.
- rst asserted 4 cycles into CONV → next cycle ready=1, bcd=0, no valid pulse. A new start then converts correctly.
- ovf_in pulse → ovf_sticky=1 and held. clr_ovf alone → 0. ovf_in and clr_ovf in the same cycle → stays 1.
- With COUNT_BCD_BLANK_EN defined:
  - bin=7 → blank=3'b110.
  - bin=40 → blank=3'b100.
  - bin=0 → blank=3'b110.

Source files
------------

// File: rtl/count_bcd_pkg.sv
// Shared constants and FSM encoding for the count_bcd_conv binary-to-BCD stage.
package count_bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned ADD3_THRESH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
    import count_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Conditional +3 so the following left shift carries correctly into the next digit
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(ADD3_THRESH)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/count_bcd_conv.sv
// Sequential double-dabble converter for the counter value, with start/ready/valid
// handshake and a sticky overflow flag.
// Optional macro COUNT_BCD_BLANK_EN adds a leading-zero blanking output.
module count_bcd_conv
    import count_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    input  logic                          ovf_in,
    input  logic                          clr_ovf,
    output logic                          ready,
    output logic                          valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
`ifdef COUNT_BCD_BLANK_EN
    output logic [DIGITS-1:0]             blank,
`endif
    output logic                          ovf_sticky
);

    localparam int unsigned BCD_W      = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SR_W       = BCD_W + WIDTH;
    localparam int unsigned CNT_W      = $clog2(WIDTH + 1);
    // ceil(WIDTH * log10(2)) with log10(2) ~= 0.30103
    localparam int unsigned MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    // Refuse to build a converter that cannot represent the largest input
    generate
        if (DIGITS < MIN_DIGITS) begin : g_digits_chk
            $error("count_bcd_conv: DIGITS too small for WIDTH");
        end
    endgenerate

    state_e             state_q;
    logic [BCD_W-1:0]   acc_q;
    logic [WIDTH-1:0]   sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q;
    logic               valid_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;

    logic [BCD_W-1:0]   acc_adj;
    logic [SR_W-1:0]    shift_d;
    logic [BCD_W-1:0]   acc_d;
    logic [WIDTH-1:0]   sr_d;

    // One correction cell per BCD digit of the accumulator
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3_digit u_add3 (
                .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Corrected accumulator and binary remainder shifted left as one register
    assign shift_d = {acc_adj, sr_q} << 1;
    assign acc_d   = shift_d[SR_W-1:WIDTH];
    assign sr_d    = shift_d[WIDTH-1:0];

`ifdef COUNT_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_d;

    // Digit i is blank when it and every more significant digit are zero; digit 0 always shows
    always_comb begin
        logic run;
        run     = 1'b1;
        blank_d = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            run        = run & (acc_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_d[i] = run;
        end
    end
`endif

    // Conversion FSM; bcd/valid are loaded on the last iteration so they appear in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            bcd_q   <= '0;
`ifdef COUNT_BCD_BLANK_EN
            blank_q <= ~DIGITS'(1);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (start) begin
                        sr_q    <= bin;
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(WIDTH);
                        ready_q <= 1'b0;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    acc_q <= acc_d;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_DONE;
                        bcd_q   <= acc_d;
                        valid_q <= 1'b1;
`ifdef COUNT_BCD_BLANK_EN
                        blank_q <= blank_d;
`endif
                    end
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow record; a new pulse wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_ovf) | ovf_in;
        end
    end

    assign ready      = ready_q;
    assign valid      = valid_q;
    assign bcd        = bcd_q;
    assign ovf_sticky = ovf_q;
`ifdef COUNT_BCD_BLANK_EN
    assign blank      = blank_q;
`endif

endmodule
